// File: rtl/conv_sequencer.sv
// Time-multiplexed FIR filter: one shared 12x12 multiplier walks DEPTH taps per sample,
// with a double-buffered coefficient bank so kernels can be reloaded without glitching output.
module conv_sequencer #(
    parameter int DEPTH = 8,   // power of two, 2..64
    parameter int SHIFT = 11
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [11:0]              sample_in,
    input  logic                     sample_valid,
    input  logic                     toggle_en,
    input  logic                     kernel_wr_en,
    input  logic [$clog2(DEPTH)-1:0] kernel_wr_addr,
    input  logic [11:0]              kernel_wr_data,
    input  logic                     kernel_commit,
    output logic [11:0]              sample_out,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int ACC_W = 24 + IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [11:0]      history [DEPTH];
    logic [11:0]      shadow  [DEPTH];
    logic [11:0]      active  [DEPTH];
    logic [IDX_W-1:0] idx;
    logic [ACC_W-1:0] acc;
    logic             enabled;
    logic             commit_pending;

    logic             accept;
    logic             copy_now;
    logic [23:0]      product;
    logic [ACC_W-1:0] acc_shifted;
    logic [11:0]      filtered;

    // A sample is only taken in IDLE; anything arriving later is dropped.
    assign accept   = (state == IDLE) && sample_valid;
    assign copy_now = (state == IDLE) && (kernel_commit || commit_pending);
    assign busy     = (state != IDLE);

    assign product     = history[idx] * active[idx];
    assign acc_shifted = acc >> SHIFT;
    assign filtered    = (acc_shifted > ACC_W'(4095)) ? 12'hFFF : acc_shifted[11:0];

    // NOTE: every signal driven in always_comb gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_valid) state_next = MAC;
            MAC:     if (idx == IDX_W'(DEPTH - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values of its neighbours, which the history shift and bank copy rely on.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the arrays are plain flops, so resetting them is legal here and gives a defined
    // (all-zero) kernel and history straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) history[i] <= '0;
        end else if (accept) begin
            history[0] <= sample_in;
            for (int i = 1; i < DEPTH; i++) history[i] <= history[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
        end else if (kernel_wr_en) begin
            shadow[kernel_wr_addr] <= kernel_wr_data;
        end
    end

    // Copy only in IDLE so the kernel stays frozen for the whole MAC/DONE pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) active[i] <= '0;
        end else if (copy_now) begin
            active <= shadow;
        end
    end

    // Commits landing mid-computation collapse into one deferred copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_pending <= 1'b0;
        end else if (state == IDLE) begin
            commit_pending <= 1'b0;
        end else if (kernel_commit) begin
            commit_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx <= '0;
            acc <= '0;
        end else if (accept) begin
            idx <= '0;
            acc <= '0;
        end else if (state == MAC) begin
            acc <= acc + ACC_W'(product);
            idx <= idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enabled <= 1'b0;
        end else if (toggle_en) begin
            enabled <= ~enabled;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_out <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= (state == DONE);
            overrun   <= sample_valid && (state != IDLE);
            if (state == DONE) begin
                sample_out <= enabled ? filtered : history[0];
            end
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: a reference FIR model pushes expected outputs and due
// cycles into a scoreboard that a negedge monitor pops whenever out_valid fires.
module tb_conv_sequencer;

    localparam int DEPTH = 8;
    localparam int SHIFT = 11;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [11:0]   sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          toggle_en = 1'b0;
    logic          kernel_wr_en = 1'b0;
    logic [AW-1:0] kernel_wr_addr = '0;
    logic [11:0]   kernel_wr_data = '0;
    logic          kernel_commit = 1'b0;
    logic [11:0]   sample_out;
    logic          out_valid;
    logic          busy;
    logic          overrun;

    conv_sequencer #(.DEPTH(DEPTH), .SHIFT(SHIFT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .toggle_en      (toggle_en),
        .kernel_wr_en   (kernel_wr_en),
        .kernel_wr_addr (kernel_wr_addr),
        .kernel_wr_data (kernel_wr_data),
        .kernel_commit  (kernel_commit),
        .sample_out     (sample_out),
        .out_valid      (out_valid),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] value;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          ov_count = 0;
    logic [11:0] last_out = '0;

    logic [11:0] m_hist   [DEPTH];
    logic [11:0] m_shadow [DEPTH];
    logic [11:0] m_active [DEPTH];
    logic        m_en;
    logic        m_pending;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every out_valid must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            ov_count++;
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_latency", cyc, e.due);
                check("sample_out", 32'(sample_out), 32'(e.value));
                last_out = sample_out;
            end
        end
    end

    function automatic logic [11:0] model_out();
        longint sum = 0;
        for (int i = 0; i < DEPTH; i++) sum += longint'(m_hist[i]) * longint'(m_active[i]);
        sum = sum >> SHIFT;
        if (!m_en) return m_hist[0];
        return (sum > 4095) ? 12'hFFF : 12'(sum);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_hist[i]   = '0;
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_en      = 1'b0;
        m_pending = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        sb.delete();
    endtask

    // Accepted sample: DUT must be IDLE; optionally commits on the same edge.
    task automatic send(input logic [11:0] data, input bit with_commit);
        exp_t e;
        @(negedge clk);
        sample_in     = data;
        sample_valid  = 1'b1;
        kernel_commit = with_commit;
        @(negedge clk);
        sample_valid  = 1'b0;
        kernel_commit = 1'b0;
        if (with_commit || m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        for (int i = DEPTH - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = data;
        e.value = model_out();
        e.due   = cyc + DEPTH + 1;
        sb.push_back(e);
    endtask

    // Sample offered while busy: must be dropped with an overrun pulse.
    task automatic drop(input logic [11:0] data);
        @(negedge clk);
        sample_in    = data;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("overrun_pulse", 32'(overrun), 32'd1);
        check("busy_during_drop", 32'(busy), 32'd1);
        @(negedge clk);
        check("overrun_one_cycle", 32'(overrun), 32'd0);
    endtask

    task automatic write_tap(input int addr, input logic [11:0] data);
        @(negedge clk);
        kernel_wr_en   = 1'b1;
        kernel_wr_addr = AW'(addr);
        kernel_wr_data = data;
        @(negedge clk);
        kernel_wr_en   = 1'b0;
        m_shadow[addr] = data;
    endtask

    task automatic commit(input bit inflight);
        @(negedge clk);
        kernel_commit = 1'b1;
        @(negedge clk);
        kernel_commit = 1'b0;
        if (inflight) m_pending = 1'b1;
        else m_active = m_shadow;
    endtask

    task automatic toggle();
        @(negedge clk);
        toggle_en = 1'b1;
        @(negedge clk);
        toggle_en = 1'b0;
        m_en = ~m_en;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && !busy) break;
            @(negedge clk);
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ov_before;
        model_reset();
        #1;
        check("reset_sample_out", 32'(sample_out), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Bypass after reset, exact latency checked by the monitor.
        send(12'h123, 1'b0);
        wait_idle();
        check("bypass_0x123", 32'(last_out), 32'h123);

        // Unity tap0.
        write_tap(0, 12'h800);
        commit(1'b0);
        toggle();
        send(12'h7FF, 1'b0);
        wait_idle();
        check("unity_7ff", 32'(last_out), 32'h7FF);
        send(12'h000, 1'b0);
        wait_idle();
        check("unity_000", 32'(last_out), 32'h000);

        // Step response with all taps 0x100.
        do_reset();
        for (int i = 0; i < DEPTH; i++) write_tap(i, 12'h100);
        commit(1'b0);
        toggle();
        for (int i = 0; i < DEPTH; i++) begin
            send(12'h800, 1'b0);
            wait_idle();
            check("step_ramp", 32'(last_out), 32'((i + 1) * 12'h100));
        end

        // Saturation with full-scale taps and samples.
        for (int i = 0; i < DEPTH; i++) write_tap(i, 12'hFFF);
        commit(1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            send(12'hFFF, 1'b0);
            wait_idle();
        end
        check("saturate", 32'(last_out), 32'hFFF);

        // Overrun: dropped sample leaves history and in-flight result untouched.
        do_reset();
        write_tap(0, 12'h800);
        write_tap(1, 12'h400);
        commit(1'b0);
        toggle();
        send(12'h100, 1'b0);
        @(negedge clk);
        drop(12'h555);
        wait_idle();
        check("overrun_result", 32'(last_out), 32'h100);
        send(12'h200, 1'b0);
        wait_idle();
        check("after_overrun", 32'(last_out), 32'h280);

        // Commit during MAC: current uses old kernel, next uses new one.
        write_tap(0, 12'h400);
        send(12'h300, 1'b0);
        commit(1'b1);
        write_tap(1, 12'h000);
        wait_idle();
        check("old_kernel", 32'(last_out), 32'h400);
        send(12'h040, 1'b0);
        wait_idle();
        check("new_kernel", 32'(last_out), 32'h020);

        // Commit and sample on the same IDLE edge.
        write_tap(2, 12'h800);
        send(12'h000, 1'b1);
        wait_idle();
        check("same_edge_commit", 32'(last_out), 32'h300);

        // Reset mid-MAC aborts with no out_valid.
        ov_before = ov_count;
        @(negedge clk);
        sample_in    = 12'hABC;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_sample_out", 32'(sample_out), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (15) @(negedge clk);
        check("abort_no_out_valid", ov_count, ov_before);
        send(12'h321, 1'b0);
        wait_idle();
        check("fresh_after_abort", 32'(last_out), 32'h321);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
